// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: constants shared by the PWM DAC files.
//   DEFAULT_WIDTH - default code width; the PWM period is 2**WIDTH clock cycles.
package pwm_dac_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/pwm_dac_code_buffer.sv
// dac_code_buffer: code handshake plus the shadow/active code pair of the PWM DAC.
// A code is accepted whenever the shadow slot is empty. At a period boundary a
// pending code moves to the active register. If nothing is pending, a code
// accepted on that same edge bypasses the shadow slot.
// Ports:
//   clk, rst     - clock, async active-high reset
//   boundary_i   - this edge starts a new period (counter next-state is zero)
//   in_valid_i   - code offered
//   in_data_i    - offered code
//   in_ready_o   - shadow slot free
//   duty_d_o     - next-state of the active code (feeds the output compare)
//   duty_q_o     - active code
module dac_code_buffer
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] duty_d_o,
  output logic [WIDTH-1:0] duty_q_o
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             accept;

  // A full slot blocks acceptance, so a pending code is never overwritten.
  assign in_ready_o = !pend_full_q;
  assign accept     = in_valid_i && !pend_full_q;

  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    duty_d      = duty_q;
    if (boundary_i) begin
      if (pend_full_q) begin
        duty_d      = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        duty_d = in_data_i;
      end
    end else if (accept) begin
      pend_d      = in_data_i;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      duty_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      duty_q      <= duty_d;
    end
  end

  assign duty_d_o = duty_d;
  assign duty_q_o = duty_q;

endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: digital-to-time converter. A code taken over valid/ready is
// reproduced as the high time of a free-running 2**WIDTH-cycle PWM period.
// Ports:
//   clk, rst      - clock, async active-high reset
//   en            - run enable; low holds the block idle (counter parked at 0)
//   in_valid      - code offered
//   in_data       - code (duty in clock cycles)
//   in_ready      - code slot free
//   pwm_out       - registered pulse output
//   period_start  - registered one-cycle pulse on the first cycle of a period
//   cur_duty      - code currently being emitted
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] cur_duty
);

  localparam logic [WIDTH-1:0] MAX_CODE = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             boundary;
  logic [WIDTH-1:0] duty_d;
  logic [WIDTH-1:0] duty_q;

  // The counter only advances once en has been seen for a full cycle, so
  // the first running cycle after enable always has cnt == 0.
  always_comb begin
    run_d = en;
    cnt_d = '0;
    if (en && run_q) begin
      cnt_d = (cnt_q == MAX_CODE) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Every idle edge also counts as a boundary, so a pending code loads
  // while the block is disabled.
  assign boundary = (cnt_d == '0);

  dac_code_buffer #(
    .WIDTH (WIDTH)
  ) u_code_buffer (
    .clk        (clk),
    .rst        (rst),
    .boundary_i (boundary),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .duty_d_o   (duty_d),
    .duty_q_o   (duty_q)
  );

  // Outputs are computed from next-state so that, registered, they match the
  // current counter and active code in the same cycle.
  assign pwm_d = run_d && (cnt_d < duty_d);
  assign ps_d  = run_d && (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      pwm_q <= 1'b0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      pwm_q <= pwm_d;
      ps_q  <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign cur_duty     = duty_q;

endmodule
